// File: rtl/multi_signal_analyser.sv
// Change-triggered bus sampler: masked edges on dataIn are timestamped and queued
// in a first-word-fall-through FIFO drained over a valid/ready stream.
module multi_signal_analyser #(
    parameter int DATA_WIDTH = 8,
    parameter int TIME_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         dataIn,
    input  logic [DATA_WIDTH-1:0]         changeMask,
    input  logic                          enable,
    input  logic                          clearOverflow,
    output logic [DATA_WIDTH-1:0]         dataOut,
    output logic [TIME_WIDTH-1:0]         dataTime,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [$clog2(FIFO_DEPTH):0]   fillLevel,
    output logic                          overflow,
    output logic [DROP_WIDTH-1:0]         dropCount
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
        return (v == '1) ? v : v + DROP_WIDTH'(1);
    endfunction

    logic [TIME_WIDTH-1:0] timer_q, timer_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;
    logic                  primed_q, primed_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         fill_q, fill_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic [TIME_WIDTH-1:0] head_time_q, head_time_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;

    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [TIME_WIDTH-1:0] mem_time [FIFO_DEPTH];

    logic [DATA_WIDTH-1:0] diff;
    logic [CW-1:0]         remain;
    logic                  event_hit, empty, full, pop, push, drop;

    always_comb begin
        diff      = (dataIn ^ last_q) & changeMask;
        event_hit = enable && (!primed_q || (diff != '0));
        empty     = (fill_q == '0);
        full      = (fill_q == DEPTH_C);
        pop       = !empty && outReady;
        // A full FIFO still accepts a push when the head leaves at the same edge.
        push      = event_hit && (!full || pop);
        drop      = event_hit && full && !pop;

        timer_d  = timer_q + TIME_WIDTH'(1);
        last_d   = dataIn;
        primed_d = enable && (primed_q || event_hit);

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        fill_d   = fill_q + CW'(push) - CW'(pop);
        remain   = fill_q - CW'(pop);

        // Head register presents the next entry right after the edge; when nothing
        // older remains, the incoming sample itself becomes the head.
        head_data_d = head_data_q;
        head_time_d = head_time_q;
        if (fill_d != '0) begin
            if (remain == '0) begin
                head_data_d = dataIn;
                head_time_d = timer_q;
            end else begin
                head_data_d = mem_data[rd_ptr_d];
                head_time_d = mem_time[rd_ptr_d];
            end
        end

        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clearOverflow) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            drop_d     = clearOverflow ? DROP_WIDTH'(1) : sat_inc(drop_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q     <= '0;
            last_q      <= '0;
            primed_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            head_data_q <= '0;
            head_time_q <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            timer_q     <= timer_d;
            last_q      <= last_d;
            primed_q    <= primed_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            head_data_q <= head_data_d;
            head_time_q <= head_time_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= dataIn;
            mem_time[wr_ptr_q] <= timer_q;
        end
    end

    assign dataOut   = head_data_q;
    assign dataTime  = head_time_q;
    assign outValid  = !empty;
    assign fillLevel = fill_q;
    assign overflow  = overflow_q;
    assign dropCount = drop_q;

endmodule

// File: tb/tb_multi_signal_analyser.sv
// Directed bench for multi_signal_analyser with a 4-entry FIFO and a 2-bit drop counter.
module tb_multi_signal_analyser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dataIn;
    logic [7:0]  changeMask;
    logic        enable;
    logic        clearOverflow;
    logic [7:0]  dataOut;
    logic [31:0] dataTime;
    logic        outValid;
    logic        outReady;
    logic [2:0]  fillLevel;
    logic        overflow;
    logic [1:0]  dropCount;

    int n_checks = 0;
    int n_errs   = 0;

    multi_signal_analyser #(
        .DATA_WIDTH(8), .TIME_WIDTH(32), .FIFO_DEPTH(4), .DROP_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .dataIn(dataIn), .changeMask(changeMask),
        .enable(enable), .clearOverflow(clearOverflow), .dataOut(dataOut),
        .dataTime(dataTime), .outValid(outValid), .outReady(outReady),
        .fillLevel(fillLevel), .overflow(overflow), .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [7:0] d,
                            input logic [31:0] t, input logic [2:0] f);
        chk({tag, ".valid"}, 64'(outValid), 64'(v));
        chk({tag, ".data"},  64'(dataOut),  64'(d));
        chk({tag, ".time"},  64'(dataTime), 64'(t));
        chk({tag, ".fill"},  64'(fillLevel), 64'(f));
    endtask

    task automatic chk_ovf(input string tag, input logic o, input logic [1:0] c);
        chk({tag, ".ovf"},  64'(overflow),  64'(o));
        chk({tag, ".drop"}, 64'(dropCount), 64'(c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; dataIn = 8'h00; changeMask = 8'hFF; enable = 1'b0;
        clearOverflow = 1'b0; outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_head("reset", 1'b0, 8'h00, 32'd0, 3'd0);
        chk_ovf("reset", 1'b0, 2'd0);

        @(negedge clk);
        rst = 1'b1; dataIn = 8'd69; enable = 1'b1;
        tick();                                         // e1, timer 0
        chk_head("first", 1'b1, 8'd69, 32'd0, 3'd1);
        outReady = 1'b1;
        tick();                                         // e2 pop
        chk_head("pop", 1'b0, 8'd69, 32'd0, 3'd0);
        tick();                                         // e3 idle, head holds
        chk_head("hold", 1'b0, 8'd69, 32'd0, 3'd0);
        dataIn = 8'd100;
        tick();                                         // e4, timer 3
        chk_head("second", 1'b1, 8'd100, 32'd3, 3'd1);
        tick();                                         // e5 pop
        chk_head("pop2", 1'b0, 8'd100, 32'd3, 3'd0);

        dataIn = 8'h10;
        tick();                                         // e6 event, timer 5
        chk_head("ev10", 1'b1, 8'h10, 32'd5, 3'd1);
        changeMask = 8'h0F; dataIn = 8'h20;
        tick();                                         // e7 pop, masked change
        chk("masked.fill", 64'(fillLevel), 64'd0);
        chk("masked.valid", 64'(outValid), 64'd0);
        dataIn = 8'h21;
        tick();                                         // e8 event, timer 7
        chk_head("ev21", 1'b1, 8'h21, 32'd7, 3'd1);
        tick();                                         // e9 pop
        chk("pop3.fill", 64'(fillLevel), 64'd0);

        changeMask = 8'hFF; outReady = 1'b0;
        for (int i = 1; i <= 4; i++) begin              // e10..e13, timers 9..12
            dataIn = 8'(i);
            tick();
        end
        chk_head("full", 1'b1, 8'd1, 32'd9, 3'd4);
        chk_ovf("full", 1'b0, 2'd0);
        dataIn = 8'd5; tick();                          // e14 drop
        chk_ovf("drop1", 1'b1, 2'd1);
        dataIn = 8'd6; tick();                          // e15 drop
        chk_ovf("drop2", 1'b1, 2'd2);
        chk("drop2.fill", 64'(fillLevel), 64'd4);
        dataIn = 8'd7; tick();                          // e16 drop
        chk_ovf("drop3", 1'b1, 2'd3);
        dataIn = 8'd8; tick();                          // e17 saturated
        chk_ovf("dropsat", 1'b1, 2'd3);
        clearOverflow = 1'b1; dataIn = 8'd9; tick();    // e18 drop beats clear
        chk_ovf("clrdrop", 1'b1, 2'd1);
        tick();                                         // e19 clear alone
        chk_ovf("clear", 1'b0, 2'd0);
        chk_head("afterclr", 1'b1, 8'd1, 32'd9, 3'd4);

        clearOverflow = 1'b0; outReady = 1'b1; dataIn = 8'd10;
        tick();                                         // e20 pop+push while full, timer 19
        chk_head("pushpop", 1'b1, 8'd2, 32'd10, 3'd4);
        chk_ovf("pushpop", 1'b0, 2'd0);
        tick(); chk_head("drain3", 1'b1, 8'd3, 32'd11, 3'd3);
        tick(); chk_head("drain4", 1'b1, 8'd4, 32'd12, 3'd2);
        tick(); chk_head("drain10", 1'b1, 8'd10, 32'd19, 3'd1);
        tick(); chk_head("drained", 1'b0, 8'd10, 32'd19, 3'd0);

        enable = 1'b0; dataIn = 8'd7;
        tick(); chk("dis1.fill", 64'(fillLevel), 64'd0);
        tick(); chk("dis2.fill", 64'(fillLevel), 64'd0);
        enable = 1'b1;
        tick();                                         // e27, timer 26
        chk_head("reen", 1'b1, 8'd7, 32'd26, 3'd1);
        tick();                                         // e28 pop, no new event
        chk_head("reen.once", 1'b0, 8'd7, 32'd26, 3'd0);
        dataIn = 8'd5;
        tick();                                         // e29, timer 28
        chk_head("pre_rst", 1'b1, 8'd5, 32'd28, 3'd1);

        #2 rst = 1'b0;
        #1;
        chk_head("async_rst", 1'b0, 8'd0, 32'd0, 3'd0);
        chk_ovf("async_rst", 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_head("post_rst", 1'b1, 8'd5, 32'd0, 3'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
